// File: rtl/cnn_load_seq.sv
// rtl/cnn_load_seq.sv - sequences one kernel+frame load from memory into the CNN compute block.
module cnn_load_seq #(
  parameter int          FRT    = 14,
  parameter int          KSZ    = 3,
  parameter logic [15:0] W_BASE = 16'h0000,
  parameter logic [15:0] I_BASE = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        com_end,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        w_load,
  output logic [15:0] w_in,
  output logic        i_load,
  output logic [15:0] i_in,
  output logic        busy,
  output logic        done
);

  localparam int KK = KSZ * KSZ;
  localparam int N  = KK + FRT * FRT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] KK_C = CW'(KK);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] iss_cnt, iss_cnt_n;
  logic [CW-1:0] ret_cnt, ret_cnt_n;
  logic          rd_pend, rd_pend_n;
  logic          mem_rd_n, w_load_n, i_load_n, busy_n, done_n;
  logic [15:0]   mem_addr_n, w_in_n, i_in_n;
  logic [15:0]   iss_off;

  assign iss_off = 16'(iss_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      rd_pend  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      w_load   <= 1'b0;
      w_in     <= '0;
      i_load   <= 1'b0;
      i_in     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      iss_cnt  <= iss_cnt_n;
      ret_cnt  <= ret_cnt_n;
      rd_pend  <= rd_pend_n;
      mem_rd   <= mem_rd_n;
      mem_addr <= mem_addr_n;
      w_load   <= w_load_n;
      w_in     <= w_in_n;
      i_load   <= i_load_n;
      i_in     <= i_in_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    iss_cnt_n  = iss_cnt;
    ret_cnt_n  = ret_cnt;
    rd_pend_n  = mem_rd;
    mem_rd_n   = mem_rd;
    mem_addr_n = mem_addr;
    w_load_n   = 1'b0;
    w_in_n     = w_in;
    i_load_n   = i_load;
    i_in_n     = i_in;
    busy_n     = busy;
    done_n     = 1'b0;

    // rd_pend marks the cycle in which mem_rdata carries the word of the previous issue
    if (rd_pend && state == FETCH) begin
      ret_cnt_n = ret_cnt + 1'b1;
      if (ret_cnt < KK_C) begin
        w_load_n = 1'b1;
        w_in_n   = mem_rdata;
      end else begin
        i_load_n = 1'b1;
        i_in_n   = mem_rdata;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          mem_rd_n   = 1'b1;
          mem_addr_n = W_BASE;
          iss_cnt_n  = CW'(1);
          ret_cnt_n  = '0;
          busy_n     = 1'b1;
        end
      end
      FETCH: begin
        if (iss_cnt < N_C) begin
          mem_rd_n   = 1'b1;
          mem_addr_n = (iss_cnt < KK_C) ? W_BASE + iss_off
                                        : I_BASE + iss_off - 16'(KK);
          iss_cnt_n  = iss_cnt + 1'b1;
        end else begin
          mem_rd_n = 1'b0;
        end
        if (rd_pend && ret_cnt == N_C - 1'b1) state_n = HOLD;
      end
      HOLD: begin
        // last pixel stays presented until the compute block reports completion
        if (com_end) begin
          state_n  = FIN;
          i_load_n = 1'b0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnn_load_seq.sv
// tb/tb_cnn_load_seq.sv - self-checking bench for cnn_load_seq (default bases and wrapped pixel base).
module tb_cnn_load_seq;

  localparam int FRT = 14;
  localparam int KSZ = 3;
  localparam int KK  = KSZ * KSZ;
  localparam int FF  = FRT * FRT;
  localparam int N   = KK + FF;

  logic clk = 1'b0;
  logic reset, start, com_end;
  logic        mem_rd_o   [2];
  logic [15:0] mem_addr_o [2];
  logic [15:0] rdata      [2];
  logic        w_load_o   [2];
  logic [15:0] w_in_o     [2];
  logic        i_load_o   [2];
  logic [15:0] i_in_o     [2];
  logic        busy_o     [2];
  logic        done_o     [2];

  logic [15:0] mem [0:65535];
  int          ibase [2];
  logic [15:0] prev_w [2];
  logic [15:0] prev_i [2];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cnn_load_seq #(.FRT(FRT), .KSZ(KSZ), .W_BASE(16'h0000), .I_BASE(16'h0010)) dut_a (
    .clk(clk), .reset(reset), .start(start), .com_end(com_end),
    .mem_rd(mem_rd_o[0]), .mem_addr(mem_addr_o[0]), .mem_rdata(rdata[0]),
    .w_load(w_load_o[0]), .w_in(w_in_o[0]), .i_load(i_load_o[0]), .i_in(i_in_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  cnn_load_seq #(.FRT(FRT), .KSZ(KSZ), .W_BASE(16'h0000), .I_BASE(16'hFFF0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .com_end(com_end),
    .mem_rd(mem_rd_o[1]), .mem_addr(mem_addr_o[1]), .mem_rdata(rdata[1]),
    .w_load(w_load_o[1]), .w_in(w_in_o[1]), .i_load(i_load_o[1]), .i_in(i_in_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  always @(posedge clk) if (mem_rd_o[0]) rdata[0] <= mem[mem_addr_o[0]];
  always @(posedge clk) if (mem_rd_o[1]) rdata[1] <= mem[mem_addr_o[1]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, s, obs, exp);
    end
  endtask

  task automatic check_zero();
    for (int s = 0; s < 2; s++) begin
      chk("rst_mem_rd", s, 32'(mem_rd_o[s]), 0);
      chk("rst_mem_addr", s, 32'(mem_addr_o[s]), 0);
      chk("rst_w_load", s, 32'(w_load_o[s]), 0);
      chk("rst_w_in", s, 32'(w_in_o[s]), 0);
      chk("rst_i_load", s, 32'(i_load_o[s]), 0);
      chk("rst_i_in", s, 32'(i_in_o[s]), 0);
      chk("rst_busy", s, 32'(busy_o[s]), 0);
      chk("rst_done", s, 32'(done_o[s]), 0);
    end
  endtask

  // Expected outputs at cycle j after the start cycle, com_end applied in cycle eh.
  task automatic check_run(input int j, input int eh);
    logic [15:0] ea, ew, ei;
    int p;
    for (int s = 0; s < 2; s++) begin
      chk("mem_rd", s, 32'(mem_rd_o[s]), 32'(j >= 1 && j <= N));
      if (j >= 1 && j <= N) begin
        ea = (j - 1 < KK) ? 16'(j - 1) : 16'(ibase[s] + j - 1 - KK);
        chk("mem_addr", s, 32'(mem_addr_o[s]), 32'(ea));
      end
      ew = (j < 3) ? prev_w[s] : (j <= KK + 2) ? mem[j - 3] : mem[KK - 1];
      if (j < KK + 3) ei = prev_i[s];
      else begin
        p  = (j - 3 - KK < FF - 1) ? j - 3 - KK : FF - 1;
        ei = mem[16'(ibase[s] + p)];
      end
      chk("w_load", s, 32'(w_load_o[s]), 32'(j >= 3 && j <= KK + 2));
      chk("w_in", s, 32'(w_in_o[s]), 32'(ew));
      chk("i_load", s, 32'(i_load_o[s]), 32'(j >= KK + 3 && j <= eh));
      chk("i_in", s, 32'(i_in_o[s]), 32'(ei));
      chk("busy", s, 32'(busy_o[s]), 32'(j >= 1 && j <= eh));
      chk("done", s, 32'(done_o[s]), 32'(j == eh + 1));
    end
  endtask

  // Called in an IDLE cycle (cycle 0); returns in the IDLE cycle after FIN.
  task automatic run_seq(input int eh, input bit noise, input bit hold_start,
                         input bit com_always, input int abort_at);
    start   = 1'b1;
    com_end = com_always;
    for (int j = 1; j <= eh + 2; j++) begin
      tick();
      if (abort_at > 0 && j == abort_at + 1) begin
        check_zero();
        reset = 1'b0;
        start = 1'b0;
        com_end = 1'b0;
        for (int s = 0; s < 2; s++) begin
          prev_w[s] = '0;
          prev_i[s] = '0;
        end
        return;
      end
      check_run(j, eh);
      start = hold_start ||
              (noise && j <= eh + 1 && (j == 50 || j == 250 || $urandom_range(0, 15) == 0));
      com_end = com_always || j == eh ||
                (noise && j <= N + 1 && (j == 150 || $urandom_range(0, 15) == 0));
      if (j == abort_at) reset = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      prev_w[s] = mem[KK - 1];
      prev_i[s] = mem[16'(ibase[s] + FF - 1)];
    end
  endtask

  initial begin
    ibase[0] = 32'h0010;
    ibase[1] = 32'hFFF0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    for (int k = 0; k < KK; k++) mem[k] = 16'(k + 1);
    for (int p = 0; p < FF; p++) mem[16 + p] = 16'(p);
    for (int s = 0; s < 2; s++) begin
      prev_w[s] = '0;
      prev_i[s] = '0;
    end
    reset = 1'b1;
    start = 1'b1;
    com_end = 1'b1;
    tick();
    tick();
    check_zero();
    reset = 1'b0;
    start = 1'b0;
    com_end = 1'b0;
    tick();

    // directed default image, stray start/com_end pulses while busy, com_end at cycle 300
    run_seq(300, 1'b1, 1'b0, 1'b0, 0);

    // abort mid-frame, then confirm in-flight data is dropped
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    run_seq(400, 1'b0, 1'b0, 1'b0, 100);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_zero();
    end
    run_seq(300, 1'b0, 1'b0, 1'b0, 0);

    // random hold length with random noise
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    run_seq($urandom_range(N + 2, N + 40), 1'b1, 1'b0, 1'b0, 0);

    // back-to-back with start held and com_end held
    run_seq(N + 2, 1'b0, 1'b1, 1'b1, 0);
    run_seq(N + 2, 1'b0, 1'b1, 1'b1, 0);
    start = 1'b0;
    com_end = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) chk("idle_mem_rd", s, 32'(mem_rd_o[s]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_load_seq.md
CNN_LOAD_SEQ -- requirements
Module: cnn_load_seq

Interface
REQ-001 Parameter FRT, default 14, input frame side length; frame holds FRT*FRT pixels.
REQ-002 Parameter KSZ, default 3, kernel side length; kernel holds KSZ*KSZ weights.
REQ-003 Parameter W_BASE, default 16'h0000, memory word address of weight 0.
REQ-004 Parameter I_BASE, default 16'h0010, memory word address of pixel 0.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: reset, synchronous, active-high.
REQ-007 Port start, input, 1: request one weight+frame load; sampled only in IDLE.
REQ-008 Port com_end, input, 1: compute-complete flag from the computation block.
REQ-009 Port mem_rd, output, 1: memory read strobe.
REQ-010 Port mem_addr, output, 16: memory read word address.
REQ-011 Port mem_rdata, input, 16: read data, valid exactly one cycle after mem_rd/mem_addr.
REQ-012 Port w_load, output, 1: weight-stream valid to computation block.
REQ-013 Port w_in, output, 16: weight word.
REQ-014 Port i_load, output, 1: pixel-stream valid to computation block.
REQ-015 Port i_in, output, 16: pixel word.
REQ-016 Port busy, output, 1: sequence in progress.
REQ-017 Port done, output, 1: one-cycle completion pulse.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States SHALL be IDLE, FETCH, HOLD, FIN.
REQ-020 IDLE: start=1 at edge of cycle 0 -> FETCH; cycle 1 mem_rd=1, mem_addr=W_BASE, busy=1.
REQ-021 FETCH SHALL issue KSZ*KSZ+FRT*FRT consecutive reads, one per cycle, no gaps: W_BASE..W_BASE+KSZ*KSZ-1, then I_BASE..I_BASE+FRT*FRT-1; mem_rd=0 after last issue.
REQ-022 Each returned word SHALL appear on w_in/i_in two cycles after its address; weight k on cycle 3+k with w_load=1 (defaults: cycles 3..11).
REQ-023 Pixel p SHALL appear on i_in at cycle 3+KSZ*KSZ+p with i_load=1 (defaults: cycles 12..207); w_load SHALL be 0 whenever i_load=1.
REQ-024 w_load and i_load SHALL never be 1 in the same cycle; no idle cycle between last weight and first pixel.
REQ-025 After last pixel, state HOLD: i_load SHALL stay 1 and i_in SHALL hold the last pixel until com_end is sampled 1.
REQ-026 com_end sampled in HOLD -> FIN: next cycle i_load=0, done=1 for exactly one cycle, busy=0 in that same cycle; then IDLE.
REQ-027 com_end SHALL be ignored outside HOLD, including during FETCH.
REQ-028 start while busy=1 SHALL be ignored; start in the FIN cycle SHALL be ignored; start held high in IDLE SHALL begin a new sequence.
REQ-029 Address arithmetic SHALL be 16-bit modulo 2^16 (base+offset wraps past 16'hFFFF to 16'h0000).
REQ-030 Internal counters SHALL be sized for FRT*FRT+KSZ*KSZ without overflow for FRT<=64, KSZ<=7.
REQ-031 w_in/i_in SHALL hold their last value when the corresponding load is 0.

Reset
REQ-032 reset=1 at any edge SHALL force state IDLE and mem_rd, mem_addr, w_load, w_in, i_load, i_in, busy, done to 0 the next cycle, aborting any sequence in flight.
REQ-033 Data returning from reads issued before reset SHALL be discarded.
REQ-034 reset SHALL dominate start and com_end in the same cycle.

Verification
REQ-035 Memory model weights 1..9 at 0..8, pixels 0..195 at 16..211; start pulse cycle 0 -> w_in 1..9 cycles 3..11, i_in 0..195 cycles 12..207, mem_addr 0..8 then 16..211 cycles 1..205.
REQ-036 com_end asserted cycle 300 -> i_load=1, i_in=195 cycles 208..300; cycle 301 i_load=0, done=1, busy=0; cycle 302 done=0.
REQ-037 Reset asserted cycle 100 mid-frame -> cycle 101 all outputs 0, state IDLE; later start yields full correct sequence from weight 1.
REQ-038 start re-pulsed cycles 50 and 250 during busy, com_end pulsed cycle 150 -> no effect; sequence as REQ-035/036.
REQ-039 I_BASE=16'hFFF0, FRT=14 -> pixel addresses wrap FFF0..FFFF,0000..00B3; 196 pixels delivered in order.
REQ-040 start held high continuously, com_end immediately high -> HOLD lasts 1 cycle; back-to-back sequences with exactly one IDLE cycle between done and next mem_rd.
